// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared types and constants for the fcpu core.
//   REG_ADDR_W / RSV_ID_W / DATA_W : architectural widths
//   station_t                      : ROB station as seen at the commit port
//   OP_HALT                        : opcode that stops retirement until reset
//   commit_state_t                 : commit_unit sequencing states
package fcpu_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int RSV_ID_W     = 4;
   localparam int STATION_ID_W = 5;
   localparam int OPCODE_W     = 6;
   localparam int DATA_W       = 32;

   localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

   typedef struct packed {
      logic [STATION_ID_W-1:0] station_id;
      logic                    valid;
      logic                    ready;
      logic [REG_ADDR_W-1:0]   dst_reg;
      logic [OPCODE_W-1:0]     opcode;
      logic [DATA_W-1:0]       content;
   } station_t;

   typedef enum logic [1:0] {
      CS_RUN,
      CS_FLUSH,
      CS_HALT
   } commit_state_t;

endpackage

// File: rtl/commit_unit_reg_status_table.sv
// reg_status_table: per-register {busy, id} table naming each register's
// pending producer in the ROB.
//   clk, rst_n            : clock, async active-low reset (already synchronised)
//   flush                 : clear every busy bit (highest priority)
//   set_en/set_reg/set_id : dispatch reservation
//   clr_en/clr_reg/clr_id : commit-side release, only if the id still matches
//   tag_reg/tag_busy/tag_id : N_READ combinational lookup ports
module reg_status_table
   import fcpu_pkg::*;
#(
   parameter int N_READ = 6
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               set_en,
   input  logic [REG_ADDR_W-1:0]              set_reg,
   input  logic [RSV_ID_W-1:0]                set_id,
   input  logic                               clr_en,
   input  logic [REG_ADDR_W-1:0]              clr_reg,
   input  logic [RSV_ID_W-1:0]                clr_id,
   input  logic [N_READ-1:0][REG_ADDR_W-1:0]  tag_reg,
   output logic [N_READ-1:0]                  tag_busy,
   output logic [N_READ-1:0][RSV_ID_W-1:0]    tag_id
);

   localparam int N_REG = 2 ** REG_ADDR_W;

   logic [N_REG-1:0]               busy_q, busy_d;
   logic [N_REG-1:0][RSV_ID_W-1:0] id_q, id_d;

   always_comb begin
      busy_d = busy_q;
      id_d   = id_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         // Release only if the entry still names this producer; a younger
         // reservation of the same register must survive.
         if (clr_en && busy_q[clr_reg] && (id_q[clr_reg] == clr_id)) begin
            busy_d[clr_reg] = 1'b0;
         end
         // Applied after the release so a same-cycle dispatch wins.
         if (set_en) begin
            busy_d[set_reg] = 1'b1;
            id_d[set_reg]   = set_id;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         id_q   <= '0;
      end else begin
         busy_q <= busy_d;
         id_q   <= id_d;
      end
   end

   // Registered table only; no bypass of this cycle's dispatch.
   always_comb begin
      for (int k = 0; k < N_READ; k++) begin
         tag_busy[k] = busy_q[tag_reg[k]];
         tag_id[k]   = id_q[tag_reg[k]];
      end
   end

endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the reorder buffer.
//   clk, nrst                 : clock, async-assert / sync-release active-low reset
//   c_valid, c_data, c_ready  : head-of-ROB handshake
//   rob_clear                 : flush request from the branch unit
//   disp_valid/disp_reg/disp_rsv_id : dispatch reservations into the tag table
//   tag_reg/tag_busy/tag_id   : operand lookup ports
//   reg_we/reg_addr/reg_data  : registered register-file write
//   halted, retired           : HALT retired flag, committed-entry counter
module commit_unit
   import fcpu_pkg::*;
#(
   parameter int N_READ = 6,
   parameter int CNT_W  = 32
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               c_valid,
   input  station_t                           c_data,
   output logic                               c_ready,
   input  logic                               rob_clear,
   input  logic                               disp_valid,
   input  logic [REG_ADDR_W-1:0]              disp_reg,
   input  logic [RSV_ID_W-1:0]                disp_rsv_id,
   input  logic [N_READ-1:0][REG_ADDR_W-1:0]  tag_reg,
   output logic [N_READ-1:0]                  tag_busy,
   output logic [N_READ-1:0][RSV_ID_W-1:0]    tag_id,
   output logic                               reg_we,
   output logic [REG_ADDR_W-1:0]              reg_addr,
   output logic [DATA_W-1:0]                  reg_data,
   output logic                               halted,
   output logic [CNT_W-1:0]                   retired
);

   // Reset synchroniser: asserts immediately, releases two edges later.
   logic [1:0] sync_q, sync_d;
   logic       rst_int_n;

   assign sync_d    = {sync_q[0], 1'b1};
   assign rst_int_n = sync_q[1];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) sync_q <= 2'b00;
      else       sync_q <= sync_d;
   end

   commit_state_t         state_q, state_d;
   logic                  c_ready_q, c_ready_d;
   logic                  halted_q, halted_d;
   logic                  reg_we_q, reg_we_d;
   logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0]     reg_data_q, reg_data_d;
   logic [CNT_W-1:0]      retired_q, retired_d;

   logic in_run, commit, do_flush, set_en, clr_en;

   // Station fields the commit stage has no use for.
   logic unused_fields;
   assign unused_fields = ^{c_data.valid, c_data.ready,
                            c_data.station_id[STATION_ID_W-1:RSV_ID_W]};

   always_comb begin
      in_run   = (state_q == CS_RUN);
      // c_ready_q is 1 exactly when state is RUN and reset has been released.
      commit   = c_valid & c_ready_q;
      do_flush = rob_clear & in_run;
      set_en   = disp_valid & in_run & (disp_reg != '0);
      clr_en   = commit & (c_data.dst_reg != '0);

      state_d = state_q;
      if (commit && (c_data.opcode == OP_HALT)) state_d = CS_HALT;
      else if (state_q == CS_FLUSH)             state_d = CS_RUN;
      else if (do_flush)                        state_d = CS_FLUSH;

      c_ready_d = (state_d == CS_RUN);
      halted_d  = (state_d == CS_HALT);

      // Entries without a destination leave the write port idle and holding.
      reg_we_d   = clr_en;
      reg_addr_d = clr_en ? c_data.dst_reg : reg_addr_q;
      reg_data_d = clr_en ? c_data.content : reg_data_q;
      retired_d  = commit ? (retired_q + CNT_W'(1)) : retired_q;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= CS_RUN;
         c_ready_q  <= 1'b0;
         halted_q   <= 1'b0;
         reg_we_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         c_ready_q  <= c_ready_d;
         halted_q   <= halted_d;
         reg_we_q   <= reg_we_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         retired_q  <= retired_d;
      end
   end

   assign c_ready  = c_ready_q;
   assign halted   = halted_q;
   assign reg_we   = reg_we_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign retired  = retired_q;

   reg_status_table #(
      .N_READ (N_READ)
   ) u_rst (
      .clk      (clk),
      .rst_n    (rst_int_n),
      .flush    (do_flush),
      .set_en   (set_en),
      .set_reg  (disp_reg),
      .set_id   (disp_rsv_id),
      .clr_en   (clr_en),
      .clr_reg  (c_data.dst_reg),
      .clr_id   (c_data.station_id[RSV_ID_W-1:0]),
      .tag_reg  (tag_reg),
      .tag_busy (tag_busy),
      .tag_id   (tag_id)
   );

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
   import fcpu_pkg::*;

   localparam int N_READ = 6;
   localparam int CNT_W  = 4;

   logic                               clk;
   logic                               nrst;
   logic                               c_valid;
   station_t                           c_data;
   logic                               c_ready;
   logic                               rob_clear;
   logic                               disp_valid;
   logic [REG_ADDR_W-1:0]              disp_reg;
   logic [RSV_ID_W-1:0]                disp_rsv_id;
   logic [N_READ-1:0][REG_ADDR_W-1:0]  tag_reg;
   logic [N_READ-1:0]                  tag_busy;
   logic [N_READ-1:0][RSV_ID_W-1:0]    tag_id;
   logic                               reg_we;
   logic [REG_ADDR_W-1:0]              reg_addr;
   logic [DATA_W-1:0]                  reg_data;
   logic                               halted;
   logic [CNT_W-1:0]                   retired;

   int checks = 0;
   int errors = 0;

   commit_unit #(.N_READ(N_READ), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .c_valid     (c_valid),
      .c_data      (c_data),
      .c_ready     (c_ready),
      .rob_clear   (rob_clear),
      .disp_valid  (disp_valid),
      .disp_reg    (disp_reg),
      .disp_rsv_id (disp_rsv_id),
      .tag_reg     (tag_reg),
      .tag_busy    (tag_busy),
      .tag_id      (tag_id),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .halted      (halted),
      .retired     (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_commit(input logic [4:0] sid, input logic [REG_ADDR_W-1:0] dst,
                               input logic [5:0] op, input logic [DATA_W-1:0] content);
      c_valid           = 1'b1;
      c_data.station_id = sid;
      c_data.valid      = 1'b1;
      c_data.ready      = 1'b1;
      c_data.dst_reg    = dst;
      c_data.opcode     = op;
      c_data.content    = content;
   endtask

   task automatic drive_disp(input logic [REG_ADDR_W-1:0] r, input logic [RSV_ID_W-1:0] id);
      disp_valid  = 1'b1;
      disp_reg    = r;
      disp_rsv_id = id;
   endtask

   task automatic idle();
      c_valid    = 1'b0;
      rob_clear  = 1'b0;
      disp_valid = 1'b0;
   endtask

   initial begin
      nrst        = 1'b0;
      c_valid     = 1'b0;
      c_data      = '0;
      rob_clear   = 1'b0;
      disp_valid  = 1'b0;
      disp_reg    = '0;
      disp_rsv_id = '0;
      tag_reg     = '0;

      // Reset state
      tick(); tick();
      check("rst_c_ready", 64'(c_ready), 64'(0));
      check("rst_reg_we", 64'(reg_we), 64'(0));
      check("rst_retired", 64'(retired), 64'(0));
      check("rst_halted", 64'(halted), 64'(0));
      check("rst_tag_busy", 64'(tag_busy), 64'(0));
      nrst = 1'b1;
      tick(); tick(); tick(); tick();
      check("run_c_ready", 64'(c_ready), 64'(1));

      // Basic commit
      drive_commit(5'd3, 5'd5, 6'h01, 32'hDEADBEEF);
      tick(); idle();
      check("basic_we", 64'(reg_we), 64'(1));
      check("basic_addr", 64'(reg_addr), 64'(5));
      check("basic_data", 64'(reg_data), 64'hDEADBEEF);
      check("basic_retired", 64'(retired), 64'(1));

      // Store commit: tag table untouched even though the id matches reg 6
      tag_reg[0] = 5'd6;
      drive_disp(5'd6, 4'd3);
      tick(); idle();
      check("disp6_busy", 64'(tag_busy[0]), 64'(1));
      check("disp6_id", 64'(tag_id[0]), 64'(3));
      drive_commit(5'd3, 5'd0, 6'h02, 32'h12345678);
      tick(); idle();
      check("store_we", 64'(reg_we), 64'(0));
      check("store_addr_hold", 64'(reg_addr), 64'(5));
      check("store_data_hold", 64'(reg_data), 64'hDEADBEEF);
      check("store_retired", 64'(retired), 64'(2));
      check("store_tag6_busy", 64'(tag_busy[0]), 64'(1));

      // Younger producer kept
      tag_reg[1] = 5'd7;
      drive_disp(5'd7, 4'd2);
      tick();
      drive_disp(5'd7, 4'd4);
      tick(); idle();
      check("y_busy", 64'(tag_busy[1]), 64'(1));
      check("y_id", 64'(tag_id[1]), 64'(4));
      drive_commit(5'd2, 5'd7, 6'h01, 32'h77);
      tick(); idle();
      check("y_old_busy", 64'(tag_busy[1]), 64'(1));
      check("y_old_id", 64'(tag_id[1]), 64'(4));
      check("y_old_retired", 64'(retired), 64'(3));
      // Upper station_id bit is outside the tag and must be ignored
      drive_commit(5'h14, 5'd7, 6'h01, 32'h78);
      tick(); idle();
      check("y_new_busy", 64'(tag_busy[1]), 64'(0));
      check("y_new_retired", 64'(retired), 64'(4));

      // Same-cycle dispatch and matching release on reg 6: dispatch wins
      drive_commit(5'd3, 5'd6, 6'h01, 32'h66);
      drive_disp(5'd6, 4'd9);
      tick(); idle();
      check("dw_busy", 64'(tag_busy[0]), 64'(1));
      check("dw_id", 64'(tag_id[0]), 64'(9));
      check("dw_we", 64'(reg_we), 64'(1));

      // Flush
      tag_reg[0] = 5'd1; tag_reg[1] = 5'd2; tag_reg[2] = 5'd3;
      tag_reg[3] = 5'd4; tag_reg[4] = 5'd6; tag_reg[5] = 5'd8;
      drive_disp(5'd1, 4'd1); tick();
      drive_disp(5'd2, 4'd2); tick();
      drive_disp(5'd3, 4'd3); tick(); idle();
      check("pre_flush_busy", 64'(tag_busy), 64'b010111);
      rob_clear = 1'b1;
      drive_commit(5'd1, 5'd9, 6'h05, 32'h99);
      drive_disp(5'd4, 4'd5);
      tick();
      check("flush_we", 64'(reg_we), 64'(1));
      check("flush_addr", 64'(reg_addr), 64'(9));
      check("flush_data", 64'(reg_data), 64'h99);
      check("flush_retired", 64'(retired), 64'(6));
      check("flush_busy", 64'(tag_busy), 64'(0));
      check("flush_c_ready", 64'(c_ready), 64'(0));
      // During FLUSH: clear ignored, commit blocked, dispatch ignored
      drive_commit(5'd2, 5'd9, 6'h01, 32'hAA);
      drive_disp(5'd8, 4'd6);
      tick(); idle();
      check("post_flush_c_ready", 64'(c_ready), 64'(1));
      check("post_flush_we", 64'(reg_we), 64'(0));
      check("post_flush_data", 64'(reg_data), 64'h99);
      check("post_flush_retired", 64'(retired), 64'(6));
      check("post_flush_busy8", 64'(tag_busy[5]), 64'(0));

      // Back-to-back commits to one register, total commits reach 17
      for (int i = 0; i < 11; i++) begin
         drive_commit(5'(i), 5'd10, 6'h01, 32'h100 + 32'(i));
         tick();
         check("b2b_we", 64'(reg_we), 64'(1));
         check("b2b_data", 64'(reg_data), 64'h100 + 64'(i));
      end
      idle();
      check("wrap_retired", 64'(retired), 64'(1));

      // Halt with simultaneous rob_clear
      tag_reg[0] = 5'd12; tag_reg[1] = 5'd14;
      drive_disp(5'd12, 4'd7);
      tick(); idle();
      check("h_pre_busy", 64'(tag_busy[0]), 64'(1));
      drive_commit(5'd5, 5'd0, OP_HALT, 32'h0);
      rob_clear = 1'b1;
      tick();
      rob_clear = 1'b0;
      drive_commit(5'd6, 5'd13, 6'h01, 32'hBB);
      check("h_halted", 64'(halted), 64'(1));
      check("h_c_ready", 64'(c_ready), 64'(0));
      check("h_retired", 64'(retired), 64'(2));
      check("h_flush_busy", 64'(tag_busy[0]), 64'(0));
      check("h_id_kept", 64'(tag_id[0]), 64'(7));
      for (int i = 0; i < 10; i++) begin
         rob_clear = i[0];
         drive_disp(5'd14, 4'd2);
         tick();
         check("h_hold_c_ready", 64'(c_ready), 64'(0));
         check("h_hold_halted", 64'(halted), 64'(1));
      end
      check("h_hold_retired", 64'(retired), 64'(2));
      check("h_hold_we", 64'(reg_we), 64'(0));
      check("h_hold_busy14", 64'(tag_busy[1]), 64'(0));
      idle();

      // Asynchronous reset pulse mid-cycle
      #2 nrst = 1'b0;
      #1;
      check("ar_halted", 64'(halted), 64'(0));
      check("ar_retired", 64'(retired), 64'(0));
      check("ar_we", 64'(reg_we), 64'(0));
      check("ar_addr", 64'(reg_addr), 64'(0));
      check("ar_data", 64'(reg_data), 64'(0));
      check("ar_c_ready", 64'(c_ready), 64'(0));
      check("ar_busy", 64'(tag_busy), 64'(0));
      check("ar_id12", 64'(tag_id[0]), 64'(0));
      tick();
      nrst = 1'b1;
      tick(); tick(); tick(); tick();
      check("ar_run_c_ready", 64'(c_ready), 64'(1));
      check("ar_run_halted", 64'(halted), 64'(0));
      drive_commit(5'd1, 5'd5, 6'h01, 32'h55);
      tick(); idle();
      check("ar_commit_we", 64'(reg_we), 64'(1));
      check("ar_commit_data", 64'(reg_data), 64'h55);
      check("ar_commit_retired", 64'(retired), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage directly downstream of the reorder buffer. It consumes the head station through a valid/ready handshake and turns each retired entry into a registered register-file write. It also owns the register status (tag) table that dispatch and operand lookup use to find a register's pending producer, and it handles flush and halt sequencing.

## Interface
Parameters:
- N_READ, 6: number of tag-lookup ports (3 integer + 3 float operands).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  reset, asynchronous assert, active-low. Release must be synchronous to clk.
- c_valid  in  1  head entry valid and ready; driven by the ROB commit output.
- c_data  in  station_t  head station: station_id, valid, ready, dst_reg, opcode, content.
- c_ready  out  1  commit accept.
- rob_clear  in  1  flush request from the branch unit.
- disp_valid  in  1  dispatch is reserving a ROB entry this cycle.
- disp_reg  in  REG_ADDR_W  destination register of the dispatched instruction. 0 means no destination.
- disp_rsv_id  in  RSV_ID_W  ROB id assigned to that instruction.
- tag_reg  in  [N_READ][REG_ADDR_W]  lookup addresses.
- tag_busy  out  [N_READ]  register has a pending producer.
- tag_id  out  [N_READ][RSV_ID_W]  ROB id of the pending producer.
- reg_we  out  1  register-file write enable.
- reg_addr  out  REG_ADDR_W  write address.
- reg_data  out  DATA_W  write data.
- halted  out  1  a HALT has retired.
- retired  out  CNT_W  count of committed entries.

## Operation
State machine states:
- RUN: c_ready=1.
- FLUSH: c_ready=0. Lasts exactly 1 cycle, then returns to RUN.
- HALT: c_ready=0; halted=1. The only exit is reset.

State transitions (checked in this order):
- An accepted entry with opcode==OP_HALT → HALT. HALT takes priority over rob_clear arriving in the same cycle.
- rob_clear while in RUN → FLUSH.
- rob_clear while in FLUSH or HALT is ignored.

Commit (c_valid & c_ready):
- Register write: next cycle reg_we=1, reg_addr=c_data.dst_reg, reg_data=c_data.content.
  - Exception: when dst_reg==0, reg_we=0 and reg_addr/reg_data hold their previous values. This covers stores, jumps and branches.
- retired increments by 1 and wraps modulo 2**CNT_W.
- A commit in the same cycle as rob_clear completes normally; the clearing branch itself retires.

Tag table (2**REG_ADDR_W entries of {busy, id}):
- Dispatch, when disp_valid & disp_reg!=0 and state is RUN: busy[disp_reg]<=1, id[disp_reg]<=disp_rsv_id.
- Commit clear: busy[dst_reg]<=0 only when busy is set and id==c_data.station_id[RSV_ID_W-1:0]. A younger producer's tag is never cleared.
- Same-cycle dispatch and commit-clear to the same register: the dispatch wins.
- Flush: rob_clear in RUN clears all busy bits at the clock edge. Flush beats both dispatch and commit-clear that cycle.
- Dispatch is ignored in FLUSH and HALT.
- Entry 0 is never busy.

Lookup: tag_busy/tag_id are purely combinational reads of the registered table. There is no same-cycle bypass.

## Timing
- Reset values: state RUN; every busy bit 0 and every id 0; reg_we 0, reg_addr 0, reg_data 0; halted 0; retired 0.
- c_ready=0 while nrst is low. An asserted nrst mid-commit drops the pending write (reg_we=0 next edge after release is not produced).
- Commit-to-write latency is 1 cycle. Throughput is 1 commit per cycle in RUN.
- c_ready depends only on state, never on c_valid. It is safe against the ROB, whose o_valid depends only on the ROB's own state.
- A tag set by dispatch is visible on lookups the cycle after.
- Back-to-back commits to the same register produce two consecutive writes; the later write wins in the register file.

## Structure
- Add to fcpu_pkg: the OP_HALT constant and a commit_state_t enum {CS_RUN, CS_FLUSH, CS_HALT}.
- station_t, RSV_ID_W, REG_ADDR_W and DATA_W already come from fcpu_pkg.
- One sub-module: reg_status_table, which holds the tag array with its set/clear/flush priority and the N_READ lookup ports.
- The FSM, write register and counter stay in commit_unit.

## Test plan
- Basic commit: after reset, commit {station_id=3, dst_reg=5, content=0xDEADBEEF}. Next cycle: reg_we=1, reg_addr=5, reg_data=0xDEADBEEF, retired=1.
- Store commit: commit with dst_reg=0. Next cycle: reg_we=0, retired increments, and the tag table is unchanged.
- Younger producer kept: dispatch reg 7 with id 2, then reg 7 with id 4. Commit id 2 → tag_busy for reg 7 stays 1 and tag_id=4. Commit id 4 → busy=0.
- Flush: busy set on regs 1, 2, 3. Assert rob_clear together with a commit of dst_reg=9 and a dispatch to reg 4. Required: the write to reg 9 occurs; all busy are 0 the next cycle; c_ready=0 for 1 cycle, then 1.
- Halt: commit opcode OP_HALT with rob_clear high in the same cycle. Required: halted=1, c_ready stays 0 for 10 cycles, and an async nrst pulse restores every reset value.
- Counter wrap: with CNT_W=4, perform 17 commits → retired=1.
